// File: rtl/alu_share_pkg.sv
// Shared definitions for the alu_share front-end: op codes, FSM states, default width.
// Optional grant statistics are enabled with the ALU_SHARE_STATS_EN macro.
package alu_share_pkg;

    localparam int ALU_W = 16;

    localparam logic [2:0] OP_NOT = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_DEC = 3'b100;
    localparam logic [2:0] OP_ADD = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_INC = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_share_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping
// from NREQ-1 back to 0.
module rr_pick #(
    parameter  int NREQ = 4,
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [PW-1:0]   o_gnt_idx,
    output logic            o_any
);

    int w_j;

    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        o_any     = 1'b0;
        w_j       = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_j = int'(i_ptr) + k;
            if (w_j >= NREQ) begin
                w_j = w_j - NREQ;
            end
            if (!o_any && i_req[w_j]) begin
                o_any        = 1'b1;
                o_gnt[w_j]   = 1'b1;
                o_gnt_idx    = PW'(w_j);
            end
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin shared ALU front-end: accept one request, execute, return tagged result.
// Define ALU_SHARE_STATS_EN to add per-requester saturating grant counters.
module alu_share_ctrl
    import alu_share_pkg::*;
#(
    parameter  int NREQ = 4,
    parameter  int W    = ALU_W,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ*3-1:0] req_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IW-1:0]     rsp_id,
    output logic [W-1:0]      rsp_result,
    output logic              rsp_zero,
    output state_t            o_dbg_state
`ifdef ALU_SHARE_STATS_EN
    ,
    input  logic [IW-1:0]     stat_sel,
    output logic [15:0]       stat_count
`endif
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; valid and payload must be held until then, and ready never depends on payload.

    state_t            r_state;
    state_t            w_next;
    logic [IW-1:0]     r_ptr;
    logic [W-1:0]      r_a;
    logic [W-1:0]      r_b;
    logic [2:0]        r_op;
    logic [IW-1:0]     r_id;
    logic [W-1:0]      r_result;
    logic              r_zero;
    logic [W-1:0]      w_alu;
    logic [NREQ-1:0]   w_gnt;
    logic [IW-1:0]     w_gnt_idx;
    logic              w_any;
    logic              w_accept;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .i_req     (req_valid),
        .i_ptr     (r_ptr),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_any     (w_any)
    );

    always_comb begin
        w_next    = r_state;
        req_ready = '0;
        w_accept  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    req_ready = w_gnt;
                    w_accept  = 1'b1;
                    w_next    = S_EXEC;
                end
            end
            S_EXEC:  w_next = S_RESP;
            S_RESP:  if (rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_alu = '0;
        case (r_op)
            OP_NOT:  w_alu = ~r_a;
            OP_AND:  w_alu = r_a & r_b;
            OP_OR:   w_alu = r_a | r_b;
            OP_XOR:  w_alu = r_a ^ r_b;
            OP_DEC:  w_alu = r_a - W'(1);
            OP_ADD:  w_alu = r_a + r_b;
            OP_SUB:  w_alu = r_a - r_b;
            OP_INC:  w_alu = r_a + W'(1);
            default: w_alu = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_id     <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_a  <= req_a[int'(w_gnt_idx)*W +: W];
                r_b  <= req_b[int'(w_gnt_idx)*W +: W];
                r_op <= req_op[int'(w_gnt_idx)*3 +: 3];
                r_id <= w_gnt_idx;
                r_ptr <= (w_gnt_idx == IW'(NREQ-1)) ? '0 : w_gnt_idx + IW'(1);
            end
            if (r_state == S_EXEC) begin
                r_result <= w_alu;
                r_zero   <= (w_alu == '0);
            end
        end
    end

    assign rsp_valid   = (r_state == S_RESP);
    assign rsp_id      = r_id;
    assign rsp_result  = r_result;
    assign rsp_zero    = r_zero;
    assign o_dbg_state = r_state;

`ifdef ALU_SHARE_STATS_EN
    logic [15:0] r_stat_cnt [NREQ];

    // Counters saturate at 16'hFFFF rather than wrapping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                r_stat_cnt[i] <= '0;
            end
        end else if (w_accept && (r_stat_cnt[w_gnt_idx] != 16'hFFFF)) begin
            r_stat_cnt[w_gnt_idx] <= r_stat_cnt[w_gnt_idx] + 16'd1;
        end
    end

    assign stat_count = (int'(stat_sel) < NREQ) ? r_stat_cnt[stat_sel] : 16'h0000;
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed self-checking bench for alu_share_ctrl (NREQ=4, W=16).
// Stat-counter checks are compiled in when ALU_SHARE_STATS_EN is defined.
module tb_alu_share_ctrl;
    import alu_share_pkg::*;

    localparam int NREQ = 4;
    localparam int W    = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ*3-1:0] req_op;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [W-1:0]      rsp_result;
    logic              rsp_zero;
    state_t            dbg_state;
`ifdef ALU_SHARE_STATS_EN
    logic [1:0]        stat_sel;
    logic [15:0]       stat_count;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [1:0] exp_q[$];

    always #5 clk = ~clk;

    alu_share_ctrl #(.NREQ(NREQ), .W(W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result),
        .rsp_zero    (rsp_zero),
        .o_dbg_state (dbg_state)
`ifdef ALU_SHARE_STATS_EN
        ,
        .stat_sel    (stat_sel),
        .stat_count  (stat_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                           input logic [2:0] op);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_op[i*3 +: 3] = op;
        req_valid[i]     = 1'b1;
    endtask

    // Issue one op from an idle controller with rsp_ready high and check the full timeline.
    task automatic run_single(input string tag, input int i, input logic [15:0] a,
                              input logic [15:0] b, input logic [2:0] op,
                              input logic [15:0] exp_res);
        int cyc;
        rsp_ready = 1'b1;
        set_req(i, a, b, op);
        #1;
        cyc = 0;
        while (!req_ready[i] && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_acc_wait"}, cyc, 0);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        check({tag, "_exec"}, dbg_state, S_EXEC);
        check({tag, "_noval"}, rsp_valid, 1'b0);
        @(posedge clk); #1;
        check({tag, "_valid"}, rsp_valid, 1'b1);
        check({tag, "_res"}, rsp_result, exp_res);
        check({tag, "_id"}, rsp_id, i);
        check({tag, "_zero"}, rsp_zero, exp_res == 16'h0000);
        @(posedge clk); #1;
        check({tag, "_idle"}, dbg_state, S_IDLE);
    endtask

    initial begin
        int got;
        int cyc;
        int last;
        logic [1:0] e_id;

        req_a = '0;
        req_b = '0;
        req_op = '0;
`ifdef ALU_SHARE_STATS_EN
        stat_sel = '0;
`endif
        apply_reset();
        #1;
        check("rst_state", dbg_state, S_IDLE);
        check("rst_ready", req_ready, 4'b0000);
        check("rst_valid", rsp_valid, 1'b0);
        check("rst_id", rsp_id, 2'd0);
        check("rst_res", rsp_result, 16'h0000);
        check("rst_zero", rsp_zero, 1'b0);

        // Functional vectors, all eight ops, with hand-computed results.
        run_single("add", 0, 16'h00F0, 16'h0F0F, OP_ADD, 16'h0FFF);
        run_single("inc", 1, 16'hFFFF, 16'h1234, OP_INC, 16'h0000);
        run_single("dec", 2, 16'h0000, 16'h0000, OP_DEC, 16'hFFFF);
        run_single("sub", 3, 16'h0003, 16'h0005, OP_SUB, 16'hFFFE);
        run_single("not", 0, 16'h1234, 16'h5555, OP_NOT, 16'hEDCB);
        run_single("and", 1, 16'hF0F0, 16'hFF00, OP_AND, 16'hF000);
        run_single("or",  2, 16'h00F0, 16'h0F00, OP_OR,  16'h0FF0);
        run_single("xor", 3, 16'hFFFF, 16'h0F0F, OP_XOR, 16'hF0F0);

        // Round-robin with all requesters held valid from a fresh pointer.
        apply_reset();
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, 16'h0011 * 16'(i + 1), 16'h0100, OP_ADD);
        end
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        got = 0; cyc = 0; last = -1;
        while (got < 6 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (rsp_valid) begin
                e_id = exp_q.pop_front();
                check("rr_id", rsp_id, e_id);
                check("rr_res", rsp_result, 16'h0011 * 16'(e_id + 1) + 16'h0100);
                if (last >= 0) check("rr_gap", cyc - last, 3);
                last = cyc;
                got++;
                if (got == 6) req_valid = '0;
            end
        end
        check("rr_count", got, 6);
        @(posedge clk); #1;
        check("rr_idle", dbg_state, S_IDLE);

        // Backpressure: hold RESP for several cycles with another requester waiting.
        rsp_ready = 1'b0;
        set_req(1, 16'hFFFF, 16'h0F0F, OP_XOR);
        #1 check("bp_acc", req_ready, 4'b0010);
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        set_req(3, 16'h0001, 16'h0001, OP_ADD);
        for (int k = 0; k < 6; k++) begin
            check("bp_valid", rsp_valid, 1'b1);
            check("bp_res", rsp_result, 16'hF0F0);
            check("bp_id", rsp_id, 2'd1);
            check("bp_ready0", req_ready, 4'b0000);
            if (k < 5) begin
                @(posedge clk); #1;
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_idle", dbg_state, S_IDLE);
        check("bp_rel", rsp_valid, 1'b0);
        check("bp_next", req_ready, 4'b1000);
        req_valid = '0;
        @(posedge clk); #1;

        // Reset while an op is in EXEC: no response, pointer back to 0.
        set_req(2, 16'h0005, 16'h0006, OP_ADD);
        #1 check("mr_acc", req_ready, 4'b0100);
        @(posedge clk); #1;
        req_valid = '0;
        check("mr_exec", dbg_state, S_EXEC);
        rst_n = 1'b0;
        #1 check("mr_state", dbg_state, S_IDLE);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("mr_norsp", rsp_valid, 1'b0);
            if (k == 1) rst_n = 1'b1;
        end
        req_valid = 4'hF;
        #1 check("mr_ptr0", req_ready, 4'b0001);
        req_valid = '0;
        @(posedge clk); #1;

`ifdef ALU_SHARE_STATS_EN
        for (int k = 0; k < 3; k++) begin
            run_single("st_op", 1, 16'h0002, 16'h0003, OP_ADD, 16'h0005);
        end
        for (int s = 0; s < NREQ; s++) begin
            stat_sel = 2'(s);
            #1 check("stat_cnt", stat_count, (s == 1) ? 32'd3 : 32'd0);
        end
`endif

        run_single("mr_req2", 2, 16'h0007, 16'h0001, OP_SUB, 16'h0006);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
